// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-ALU datapath (addu/subu/ori/lui/lw/sw/beq/j).
// Define MC_CTRL_ILLEGAL_TRAP_EN to freeze in ILLEGAL with a sticky flag; otherwise it is a nop.
module mc_ctrl #(
  parameter int unsigned RET_W   = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               alu_srca,
  output logic [1:0]         alu_srcb,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic [RET_W-1:0]   retired,
  output logic               illegal
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluOri = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluLui = ALUOP_W'(3);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr,
    StMemRd, StWbMem, StMemWr, StBranch, StJump, StIllegal
  } state_e;

  state_e           state_q, state_d;
  logic [RET_W-1:0] retired_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != StFetch && state_d == StFetch) retired_q <= retired_q + RET_W'(1);
    end
  end

  assign retired = retired_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  illegal_q <= 1'b0;
    else if (state_d == StIllegal) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpRtype:     state_d = (funct == FnAddu || funct == FnSubu) ? StExecR : StIllegal;
          OpOri, OpLui: state_d = StExecI;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          default:     state_d = StIllegal;
        endcase
      end
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StWbMem;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StWbR, StWbI, StWbMem, StBranch, StJump: state_d = StFetch;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      StIllegal: state_d = StIllegal;
`else
      StIllegal: state_d = StFetch;
`endif
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_srca   = 1'b0;
    alu_srcb   = 2'd0;
    ALUOp      = AluAdd;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        alu_srcb = 2'd1;
        ir_we    = mem_ready;
        pc_we    = mem_ready;
      end
      StDecode:  alu_srcb = 2'd3;
      StExecR: begin
        alu_srca = 1'b1;
        ALUOp    = (funct == FnSubu) ? AluSub : AluAdd;
      end
      StWbR: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      StExecI: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
        ALUOp    = (opcode == OpLui) ? AluLui : AluOri;
      end
      StWbI:     reg_we = 1'b1;
      StMemAddr: begin
        alu_srca = 1'b1;
        alu_srcb = 2'd2;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StWbMem: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      StBranch: begin
        alu_srca = 1'b1;
        ALUOp    = AluSub;
        pc_src   = 2'd1;
        pc_we    = zero;
      end
      StJump: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
      end
      default: ;
    endcase
    // Reset forces the strobes low even though the state register already reads FETCH.
    if (!reset_n) begin
      mem_req = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table, randomized instructions vs a per-class model,
// and hand sequences for illegal opcodes and reset during a store.
module tb_mc_ctrl;

  logic        clk, reset_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, alu_srca, reg_we, reg_dst, mem_to_reg;
  logic [1:0]  pc_src, alu_srcb;
  logic [3:0]  ALUOp;
  logic [31:0] retired;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  int ret_model = 0;
  int errs;

  mc_ctrl #(.RET_W(32), .ALUOP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .ALUOp(ALUOp),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retired(retired),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int op; int fn; int z; int fw; int mw;
    int cyc; int pc; int rg; int wr; int alu; int sb; int rd; int m2r;
  } vec_t;

  typedef struct {
    int endf; int ir; int pc; int rg; int wr; int unst; int alu; int sb; int rd; int m2r;
  } res_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Expected per-instruction behaviour from the instruction class alone.
  function automatic vec_t model(input int op, input int fn, input int z, input int fw,
                                 input int mw);
    vec_t e;
    e = '{op, fn, z, fw, mw, 3 + fw, 1, 0, 0, 0, 0, 0, 0};
    case (op)
      'h00: begin e.cyc = 4 + fw; e.rg = 1; e.rd = 1; e.alu = (fn == 'h23) ? 1 : 0; end
      'h0D: begin e.cyc = 4 + fw; e.rg = 1; e.alu = 2; e.sb = 2; end
      'h0F: begin e.cyc = 4 + fw; e.rg = 1; e.alu = 3; e.sb = 2; end
      'h23: begin e.cyc = 5 + fw + mw; e.rg = 1; e.m2r = 1; e.sb = 2; end
      'h2B: begin e.cyc = 4 + fw + mw; e.wr = 1; e.sb = 2; end
      'h04: begin e.pc = 1 + z; e.alu = 1; end
      'h02: e.pc = 2;
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_instr(input vec_t v, output res_t r);
    int k, waited, acc;
    logic prev_wait;
    logic [2:0] prev_sig;
    r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    k = -1; waited = 0; acc = 0; prev_wait = 1'b0; prev_sig = '0;
    opcode = 6'(v.op); funct = 6'(v.fn); zero = 1'(v.z);
    for (int c = 0; c < v.cyc; c++) begin
      @(negedge clk);
      if (mem_req) mem_ready = (waited >= ((acc == 0) ? v.fw : v.mw));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_wait && ({mem_req, mem_we, iord} !== prev_sig)) r.unst++;
      prev_wait = mem_req && !mem_ready;
      prev_sig  = {mem_req, mem_we, iord};
      if (mem_req && !mem_ready) waited++;
      if (mem_req && mem_ready) begin waited = 0; acc++; end
      if (mem_req && mem_we && mem_ready) r.wr++;
      r.ir += int'(ir_we);
      r.pc += int'(pc_we);
      r.rg += int'(reg_we);
      if (ir_we) k = 0;
      else if (k >= 0) k++;
      if (k == 2) begin r.alu = int'(ALUOp); r.sb = int'(alu_srcb); end
      if (reg_we) begin r.rd = int'(reg_dst); r.m2r = int'(mem_to_reg); end
    end
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #1 r.endf = int'(mem_req && !iord && !mem_we && alu_srcb == 2'd1);
  endtask

  task automatic check_res(input string nm, input res_t r, input vec_t e);
    ret_model++;
    chk({nm, ".back_in_fetch"}, r.endf, 1);
    chk({nm, ".ir_we"}, r.ir, 1);
    chk({nm, ".pc_we"}, r.pc, e.pc);
    chk({nm, ".reg_we"}, r.rg, e.rg);
    chk({nm, ".mem_write"}, r.wr, e.wr);
    chk({nm, ".aluop"}, r.alu, e.alu);
    chk({nm, ".srcb"}, r.sb, e.sb);
    chk({nm, ".reg_dst"}, r.rd, e.rd);
    chk({nm, ".mem_to_reg"}, r.m2r, e.m2r);
    chk({nm, ".unstable"}, r.unst, 0);
    chk({nm, ".retired"}, retired, ret_model);
  endtask

  initial begin
    res_t r;
    vec_t e;
    int ops [8] = '{'h00, 'h00, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h02};
    int fns [8] = '{'h21, 'h23, 0, 0, 0, 0, 0, 0};

    //         op     fn    z fw mw cyc pc rg wr alu sb rd m2r
    tbl[0] = '{'h00, 'h21, 0, 0, 0,  4, 1, 1, 0, 0,  0, 1, 0};  // addu
    tbl[1] = '{'h00, 'h23, 0, 0, 0,  4, 1, 1, 0, 1,  0, 1, 0};  // subu
    tbl[2] = '{'h0D, 0,    0, 0, 0,  4, 1, 1, 0, 2,  2, 0, 0};  // ori
    tbl[3] = '{'h0F, 0,    0, 0, 0,  4, 1, 1, 0, 3,  2, 0, 0};  // lui
    tbl[4] = '{'h23, 0,    0, 3, 2, 10, 1, 1, 0, 0,  2, 0, 1};  // lw with waits
    tbl[5] = '{'h2B, 0,    0, 1, 2,  7, 1, 0, 1, 0,  2, 0, 0};  // sw with waits
    tbl[6] = '{'h04, 0,    1, 0, 0,  3, 2, 0, 0, 1,  0, 0, 0};  // beq taken
    tbl[7] = '{'h04, 0,    0, 0, 0,  3, 1, 0, 0, 1,  0, 0, 0};  // beq not taken
    tbl[8] = '{'h02, 0,    0, 0, 0,  3, 2, 0, 0, 0,  0, 0, 0};  // j

    reset_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    #2;
    chk("reset.strobes", {mem_req, ir_we, pc_we, reg_we}, 0);
    chk("reset.retired", retired, 0);
    chk("reset.illegal", illegal, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    #1 chk("reset.fetch", {mem_req, iord, alu_srca, alu_srcb, ALUOp}, 9'b1_0_0_01_0000);

    foreach (tbl[i]) begin
      run_instr(tbl[i], r);
      check_res($sformatf("tbl%0d", i), r, tbl[i]);
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    opcode = 6'h3F; funct = '0;
    errs = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (c >= 3 && (!illegal || mem_req || mem_we || ir_we || pc_we || reg_we)) errs++;
    end
    chk("trap.frozen", errs, 0);
    chk("trap.retired", retired, ret_model);
    @(negedge clk);
    mem_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("trap.clear", illegal, 0);
    chk("trap.retired_clr", retired, 0);
    ret_model = 0;
    @(negedge clk);
    reset_n = 1'b1;
`else
    e = model('h3F, 0, 0, 1, 0);
    run_instr(e, r);
    check_res("illegal_nop", r, e);
    chk("illegal_nop.flag", illegal, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      int s;
      s = int'($urandom_range(0, 7));
      e = model(ops[s], fns[s], int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      run_instr(e, r);
      check_res($sformatf("rnd%0d_op%0h", n, ops[s]), r, e);
    end

    // Store interrupted by reset while waiting on memory.
    opcode = 6'h2B; funct = '0;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_sw.in_memwr", {mem_req, mem_we, iord}, 3'b111);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_sw.drop", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
    chk("rst_sw.retired", retired, 0);
    ret_model = 0;
    @(negedge clk);
    reset_n = 1'b1;
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 if (mem_we || !mem_req || iord) errs++;
    end
    chk("rst_sw.after", errs, 0);
    run_instr(tbl[0], r);
    check_res("post_reset_addu", r, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the single-ALU datapath; it is the driving end of the ALU operand/opcode interface.
- Sequences FETCH/DECODE/EXEC/MEM/WB for the subset addu, subu, ori, lui, lw, sw, beq, j.
- Produces ALUOp, operand selects and all datapath write enables.
- Talks to unified instruction/data memory through a req/ready handshake and counts retired instructions.

Parameters:
- RET_W, 32, width of retired-instruction counter
- ALUOP_W, 4, width of ALUOp output (encodings fixed: ADD=0, SUB=1, ORI=2, LUI=3)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC write enable
- pc_src  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}
- alu_srca  out  1  0=PC, 1=rs data
- alu_srcb  out  2  0=rt data, 1=const 4, 2=imm (sign-ext, zero-ext for ori/lui), 3=sign-ext imm<<2
- ALUOp  out  ALUOP_W  ALU operation
- reg_we  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- retired  out  RET_W  count of completed instructions
- illegal  out  1  sticky illegal-instruction flag (feature-dependent)

Behaviour:
- Moore FSM. All outputs are decoded from the state only, except mem_ready gating and the beq pc_we.
- Unlisted outputs are 0 in each state.
- Reset (reset_n low, asynchronous): state=FETCH, retired=0, illegal=0. While reset_n is low, mem_req, ir_we, pc_we and reg_we are forced to 0.
- FETCH: mem_req=1, iord=0, alu_srca=0, alu_srcb=1, ALUOp=ADD.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Any number of wait cycles is allowed; PC/IR are written exactly once per fetch.
- DECODE: alu_srca=0, alu_srcb=3, ALUOp=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 100001 -> EXEC_R(ADD)
  - 000000 with funct 100011 -> EXEC_R(SUB)
  - 001101 -> EXEC_I(ORI)
  - 001111 -> EXEC_I(LUI)
  - 100011 / 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - anything else -> ILLEGAL
- EXEC_R: alu_srca=1, alu_srcb=0, ALUOp=ADD or SUB from funct; next WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0; next FETCH.
- EXEC_I: alu_srca=1, alu_srcb=2, ALUOp=ORI or LUI; next WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0; next FETCH.
- MEM_ADDR: alu_srca=1, alu_srcb=2, ALUOp=ADD; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1; hold until mem_ready=1; next WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; next FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready=1; next FETCH.
- BRANCH: alu_srca=1, alu_srcb=0, ALUOp=SUB, pc_src=1, pc_we=zero; next FETCH.
- JUMP: pc_we=1, pc_src=2; next FETCH.
- ILLEGAL: see Optional Feature.
- mem_req and mem_we stay stable until the mem_ready cycle; mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- retired increments by 1 on every transition into FETCH from a non-FETCH state (wraps at 2^RET_W, no saturation).
- Latency in cycles, excluding memory waits: R/I-type 4, lw 5, sw 4, beq 3, j 3.
- Reset asserted mid-instruction aborts it: no reg_we or pc_we pulse, and retired is not incremented.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL sets illegal=1 and stays in ILLEGAL, with all enables 0 and mem_req=0, until reset.
- Undefined: ILLEGAL goes to FETCH next cycle (the instruction is a nop; PC was already advanced) and counts as retired; illegal is tied 0.

Test Plan:
- addu, mem_ready=1 always -> FETCH, DECODE, EXEC_R, WB_R. reg_we=1 only in cycle 4 with reg_dst=1; ALUOp=0 in EXEC_R; retired 0->1.
- lw with mem_ready held low 3 cycles in FETCH and 2 in MEM_RD -> ir_we a single pulse on the ready cycle; mem_req/iord stable while waiting; reg_we with mem_to_reg=1 once; total 10 cycles.
- beq zero=1 then zero=0 -> pc_we=1 with pc_src=1 in BRANCH for the first, pc_we=0 for the second; ALUOp=1 in both; 3 cycles each.
- ori then lui -> ALUOp=2 then 3 in EXEC_I, alu_srcb=2, reg_dst=0.
- opcode 111111 -> with macro: illegal=1, FSM frozen, mem_req=0 for 10 cycles, cleared only by reset_n. Without macro: back to FETCH after DECODE, retired+1.
- reset_n pulsed low during MEM_WR -> outputs drop asynchronously, state=FETCH, retired=0, no mem_we after release.
